// File: rtl/tensor_core_scheduler_pkg.sv
// Shared types and sizes for the tensor core scheduler slice.
// A 4x4 int8 matrix packs element (row r, col c) at bits [8*(r*4+c) +: 8].
package tensor_core_pkg;

   localparam int ELEMENT_WIDTH = 8;
   localparam int MATRIX_DIM    = 4;
   localparam int MATRIX_WIDTH  = MATRIX_DIM * MATRIX_DIM * ELEMENT_WIDTH;

   typedef enum logic [1:0] {
      TCS_IDLE    = 2'd0,
      TCS_LOAD    = 2'd1,
      TCS_COMPUTE = 2'd2,
      TCS_RESPOND = 2'd3
   } tensor_core_scheduler_state_t;

   typedef logic requester_id_t;
   typedef logic [MATRIX_WIDTH-1:0] matrix_t;

endpackage

// File: rtl/tensor_core_scheduler_if.sv
// Request/response bundle between two requesters, a result consumer and the
// scheduler. The scheduler uses the slave view; the requester side uses master.
interface tensor_core_scheduler_if;
   import tensor_core_pkg::*;

   logic          req0_valid;
   logic          req0_ready;
   matrix_t       req0_input1;
   matrix_t       req0_input2;
   logic          req1_valid;
   logic          req1_ready;
   matrix_t       req1_input1;
   matrix_t       req1_input2;
   logic          resp_valid;
   logic          resp_ready;
   requester_id_t resp_id;
   matrix_t       resp_data;
   logic          resp_error;

   modport slave (
      input  req0_valid, req0_input1, req0_input2,
      input  req1_valid, req1_input1, req1_input2,
      input  resp_ready,
      output req0_ready, req1_ready,
      output resp_valid, resp_id, resp_data, resp_error
   );

   modport master (
      output req0_valid, req0_input1, req0_input2,
      output req1_valid, req1_input1, req1_input2,
      output resp_ready,
      input  req0_ready, req1_ready,
      input  resp_valid, resp_id, resp_data, resp_error
   );

endinterface

// File: rtl/tensor_core_scheduler_rr_arbiter.sv
// Two-input round-robin arbiter. On a tie the requester that did not win last
// time is granted; last_grant moves only when the accept strobe fires.
module tensor_core_rr_arbiter
   import tensor_core_pkg::*;
(
   input  logic          clock_in,
   input  logic          reset_n,
   input  logic          valid0,
   input  logic          valid1,
   input  logic          accept,
   output requester_id_t grant
);

   requester_id_t last_grant_reg;

   // Lone requester wins outright; tie or no request points at the other one.
   always_comb begin
      grant = ~last_grant_reg;
      if (valid0 && !valid1) begin
         grant = 1'b0;
      end else if (valid1 && !valid0) begin
         grant = 1'b1;
      end
   end

   // Remember the winner of each accepted job; reset favours req0 first.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         last_grant_reg <= 1'b1;
      end else if (accept) begin
         last_grant_reg <= grant;
      end
   end

endmodule

// File: rtl/tensor_core_scheduler.sv
// Job sequencer in front of small_tensor_core: IDLE -> LOAD -> COMPUTE -> RESPOND.
// Optional feature: define TENSOR_CORE_SCHEDULER_TIMEOUT_EN to abort a job after
// TIMEOUT_CYCLES COMPUTE cycles without a done, answering with resp_error=1.
module tensor_core_scheduler
   import tensor_core_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 32
) (
   input  logic                  clock_in,
   input  logic                  reset_n,
   tensor_core_scheduler_if.slave bus,
   output logic                  busy,
   output logic                  tensor_core_register_file_write_enable,
   output matrix_t               tensor_core_input1,
   output matrix_t               tensor_core_input2,
   input  matrix_t               tensor_core_output,
   input  logic                  is_done_with_calculation
);

   localparam logic [1:0] ST_IDLE    = TCS_IDLE;
   localparam logic [1:0] ST_LOAD    = TCS_LOAD;
   localparam logic [1:0] ST_COMPUTE = TCS_COMPUTE;
   localparam logic [1:0] ST_RESPOND = TCS_RESPOND;

   if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   logic [1:0]    state_reg;
   logic [1:0]    state_next;
   requester_id_t grant;
   requester_id_t id_reg;
   matrix_t       resp_data_reg;
   logic          ready0;
   logic          ready1;
   logic          accept;
   logic          armed_reg;
   logic          done_qualified;
   logic          timed_out;

   assign ready0 = (state_reg == ST_IDLE) && (grant == 1'b0);
   assign ready1 = (state_reg == ST_IDLE) && (grant == 1'b1);
   assign accept = (ready0 && bus.req0_valid) || (ready1 && bus.req1_valid);

   assign bus.req0_ready = ready0;
   assign bus.req1_ready = ready1;
   assign bus.resp_valid = (state_reg == ST_RESPOND);
   assign bus.resp_id    = id_reg;
   assign bus.resp_data  = resp_data_reg;

   assign busy = (state_reg != ST_IDLE);
   // The core stays cleared except while it is actually computing.
   assign tensor_core_register_file_write_enable = (state_reg != ST_COMPUTE);

   // Done is only trusted once the arming cycle has passed.
   assign done_qualified = (state_reg == ST_COMPUTE) && armed_reg && is_done_with_calculation;

   tensor_core_rr_arbiter u_arbiter (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .valid0   (bus.req0_valid),
      .valid1   (bus.req1_valid),
      .accept   (accept),
      .grant    (grant)
   );

`ifdef TENSOR_CORE_SCHEDULER_TIMEOUT_EN
   localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TIMEOUT_W-1:0] timeout_count_reg;
   logic                 resp_error_reg;

   // The last permitted COMPUTE cycle ends the job unless done arrives with it.
   assign timed_out = (state_reg == ST_COMPUTE) && !done_qualified &&
                      (timeout_count_reg == TIMEOUT_W'(TIMEOUT_CYCLES - 1));
   assign bus.resp_error = resp_error_reg;

   // Count COMPUTE cycles of the current job, restarting in LOAD.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         timeout_count_reg <= '0;
      end else if (state_reg == ST_LOAD) begin
         timeout_count_reg <= '0;
      end else if (state_reg == ST_COMPUTE) begin
         timeout_count_reg <= timeout_count_reg + 1'b1;
      end
   end

   // Error flag reflects how the current job left COMPUTE.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         resp_error_reg <= 1'b0;
      end else if (done_qualified) begin
         resp_error_reg <= 1'b0;
      end else if (timed_out) begin
         resp_error_reg <= 1'b1;
      end
   end
`else
   assign timed_out      = 1'b0;
   assign bus.resp_error = 1'b0;
`endif

   // State register.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic; RESPOND always passes through IDLE before a new grant.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE:    if (accept) state_next = ST_LOAD;
         ST_LOAD:    state_next = ST_COMPUTE;
         ST_COMPUTE: if (done_qualified || timed_out) state_next = ST_RESPOND;
         ST_RESPOND: if (bus.resp_ready) state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // armed_reg is low during the first COMPUTE cycle and high afterwards.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         armed_reg <= 1'b0;
      end else begin
         armed_reg <= (state_reg == ST_COMPUTE);
      end
   end

   // Capture the granted job's operands/ID at accept and the result at done.
   always_ff @(posedge clock_in or negedge reset_n) begin
      if (!reset_n) begin
         tensor_core_input1 <= '0;
         tensor_core_input2 <= '0;
         id_reg             <= 1'b0;
         resp_data_reg      <= '0;
      end else begin
         if (accept) begin
            tensor_core_input1 <= grant ? bus.req1_input1 : bus.req0_input1;
            tensor_core_input2 <= grant ? bus.req1_input2 : bus.req0_input2;
            id_reg             <= grant;
         end
         if (done_qualified) begin
            resp_data_reg <= tensor_core_output;
         end else if (timed_out) begin
            resp_data_reg <= '0;
         end
      end
   end

endmodule

// File: tb/tb_tensor_core_scheduler.sv
// Directed bench for tensor_core_scheduler with a behavioural small_tensor_core.
// Build with TENSOR_CORE_SCHEDULER_TIMEOUT_EN to include the timeout scenario.
module tb_tensor_core_scheduler;
   import tensor_core_pkg::*;

   localparam matrix_t IDENT  = 128'h01000000_00010000_00000100_00000001;
   localparam matrix_t B_SEQ  = 128'h100F0E0D_0C0B0A09_08070605_04030201;
   localparam matrix_t ALL2   = {16{8'h02}};
   localparam matrix_t ALL3   = {16{8'h03}};
   localparam matrix_t ALL18  = {16{8'h18}};

   logic    clock_in = 1'b0;
   logic    reset_n  = 1'b0;
   logic    busy;
   logic    core_we;
   matrix_t core_in1;
   matrix_t core_in2;
   matrix_t core_out = '0;
   logic    core_done = 1'b0;
   bit      core_stall = 1'b0;
   int      edge_cnt = 0;
   int      check_count = 0;
   int      pass_count = 0;

   always #5 clock_in = ~clock_in;

   tensor_core_scheduler_if bus_if ();

   tensor_core_scheduler #(.TIMEOUT_CYCLES(32)) dut (
      .clock_in                               (clock_in),
      .reset_n                                (reset_n),
      .bus                                    (bus_if),
      .busy                                   (busy),
      .tensor_core_register_file_write_enable (core_we),
      .tensor_core_input1                     (core_in1),
      .tensor_core_input2                     (core_in2),
      .tensor_core_output                     (core_out),
      .is_done_with_calculation               (core_done)
   );

   function automatic matrix_t matmul(input matrix_t a, input matrix_t b);
      matrix_t    c;
      logic [7:0] acc;
      c = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) begin
               acc = acc + 8'(a[8*(i*4+k) +: 8] * b[8*(k*4+j) +: 8]);
            end
            c[8*(i*4+j) +: 8] = acc;
         end
      end
      return c;
   endfunction

   // Core model: cleared while write-enable is high, done after 16 clock edges.
   always @(posedge clock_in or negedge clock_in) begin
      if (core_we) begin
         edge_cnt  <= 0;
         core_done <= 1'b0;
      end else if (edge_cnt < 16) begin
         edge_cnt <= edge_cnt + 1;
         if (edge_cnt == 15 && !core_stall) begin
            core_done <= 1'b1;
            core_out  <= matmul(core_in1, core_in2);
         end
      end
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      check_count++;
      if (got === exp) pass_count++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge clock_in);
      #1;
   endtask

   task automatic apply_reset();
      reset_n = 1'b0;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
   endtask

   // Offer a job and hold it until it is accepted; returns just after the accept edge.
   task automatic send_job(input requester_id_t who, input matrix_t a, input matrix_t b);
      int n = 0;
      if (who == 1'b0) begin
         bus_if.req0_input1 = a;
         bus_if.req0_input2 = b;
         bus_if.req0_valid  = 1'b1;
      end else begin
         bus_if.req1_input1 = a;
         bus_if.req1_input2 = b;
         bus_if.req1_valid  = 1'b1;
      end
      #1;
      while (!(who ? bus_if.req1_ready : bus_if.req0_ready) && n < 100) begin
         tick();
         n++;
      end
      check_val("accept_ready", 128'(who ? bus_if.req1_ready : bus_if.req0_ready), 128'(1));
      tick();
      if (who == 1'b0) bus_if.req0_valid = 1'b0;
      else             bus_if.req1_valid = 1'b0;
   endtask

   task automatic wait_resp(output int cycles);
      cycles = 0;
      while (!bus_if.resp_valid && cycles < 200) begin
         tick();
         cycles++;
      end
      check_val("resp_seen", 128'(bus_if.resp_valid), 128'(1));
      $display("resp id=%0d err=%0b data=%h after %0d cycles",
               bus_if.resp_id, bus_if.resp_error, bus_if.resp_data, cycles);
   endtask

   task automatic take_resp();
      bus_if.resp_ready = 1'b1;
      tick();
      bus_if.resp_ready = 1'b0;
      check_val("resp_done", 128'(bus_if.resp_valid), 128'(0));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int cyc;
      int seen;
      bus_if.req0_valid  = 1'b0;
      bus_if.req1_valid  = 1'b0;
      bus_if.req0_input1 = '0;
      bus_if.req0_input2 = '0;
      bus_if.req1_input1 = '0;
      bus_if.req1_input2 = '0;
      bus_if.resp_ready  = 1'b0;

      // Reset values
      apply_reset();
      check_val("rst_ready0", 128'(bus_if.req0_ready), 128'(1));
      check_val("rst_ready1", 128'(bus_if.req1_ready), 128'(0));
      check_val("rst_resp_valid", 128'(bus_if.resp_valid), 128'(0));
      check_val("rst_busy", 128'(busy), 128'(0));
      check_val("rst_we", 128'(core_we), 128'(1));
      check_val("rst_in1", core_in1, 128'(0));
      check_val("rst_in2", core_in2, 128'(0));
      check_val("rst_resp_id", 128'(bus_if.resp_id), 128'(0));
      check_val("rst_resp_data", bus_if.resp_data, 128'(0));
      check_val("rst_resp_error", 128'(bus_if.resp_error), 128'(0));

      // Single job on req0: identity x B = B
      send_job(1'b0, IDENT, B_SEQ);
      check_val("load_busy", 128'(busy), 128'(1));
      check_val("load_we", 128'(core_we), 128'(1));
      check_val("load_in1", core_in1, IDENT);
      check_val("load_in2", core_in2, B_SEQ);
      tick();
      check_val("compute_we", 128'(core_we), 128'(0));
      wait_resp(cyc);
      check_val("t1_id", 128'(bus_if.resp_id), 128'(0));
      check_val("t1_data", bus_if.resp_data, B_SEQ);
      check_val("t1_err", 128'(bus_if.resp_error), 128'(0));
      check_val("t1_resp_we", 128'(core_we), 128'(1));
      take_resp();
      check_val("t1_idle_busy", 128'(busy), 128'(0));

      // Both requesters valid: grants alternate 0,1,0,1 starting with req0
      apply_reset();
      bus_if.req0_input1 = IDENT;
      bus_if.req0_input2 = B_SEQ;
      bus_if.req1_input1 = ALL2;
      bus_if.req1_input2 = ALL3;
      bus_if.req0_valid  = 1'b1;
      bus_if.req1_valid  = 1'b1;
      #1;
      check_val("tie_ready0", 128'(bus_if.req0_ready), 128'(1));
      check_val("tie_ready1", 128'(bus_if.req1_ready), 128'(0));
      for (int j = 0; j < 4; j++) begin
         wait_resp(cyc);
         check_val("rr_id", 128'(bus_if.resp_id), 128'(j % 2));
         check_val("rr_data", bus_if.resp_data, (j % 2 == 0) ? B_SEQ : ALL18);
         bus_if.resp_ready = 1'b1;
         tick();
         bus_if.resp_ready = 1'b0;
         check_val("rr_resp_done", 128'(bus_if.resp_valid), 128'(0));
      end
      bus_if.req0_valid = 1'b0;
      bus_if.req1_valid = 1'b0;
      tick();

      // Stalled consumer: response held stable, no new grant until handshake
      send_job(1'b0, ALL2, ALL3);
      bus_if.req1_input1 = IDENT;
      bus_if.req1_input2 = B_SEQ;
      bus_if.req1_valid  = 1'b1;
      wait_resp(cyc);
      check_val("hold_data0", bus_if.resp_data, ALL18);
      for (int k = 0; k < 5; k++) begin
         tick();
         check_val("hold_valid", 128'(bus_if.resp_valid), 128'(1));
         check_val("hold_data", bus_if.resp_data, ALL18);
         check_val("hold_id", 128'(bus_if.resp_id), 128'(0));
         check_val("hold_ready0", 128'(bus_if.req0_ready), 128'(0));
         check_val("hold_ready1", 128'(bus_if.req1_ready), 128'(0));
      end
      bus_if.resp_ready = 1'b1;
      tick();
      bus_if.resp_ready = 1'b0;
      check_val("after_hs_ready1", 128'(bus_if.req1_ready), 128'(1));
      send_job(1'b1, IDENT, B_SEQ);
      wait_resp(cyc);
      check_val("pend_id", 128'(bus_if.resp_id), 128'(1));
      check_val("pend_data", bus_if.resp_data, B_SEQ);
      take_resp();

      // Reset pulse during COMPUTE discards the job
      send_job(1'b0, IDENT, ALL3);
      tick();
      tick();
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      check_val("arst_we", 128'(core_we), 128'(1));
      check_val("arst_resp_valid", 128'(bus_if.resp_valid), 128'(0));
      check_val("arst_busy", 128'(busy), 128'(0));
      check_val("arst_in1", core_in1, 128'(0));
      tick();
      reset_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (bus_if.resp_valid || busy) seen++;
      end
      check_val("arst_no_stale", 128'(seen), 128'(0));
      send_job(1'b0, ALL2, ALL3);
      wait_resp(cyc);
      check_val("arst_next_id", 128'(bus_if.resp_id), 128'(0));
      check_val("arst_next_data", bus_if.resp_data, ALL18);
      take_resp();

`ifdef TENSOR_CORE_SCHEDULER_TIMEOUT_EN
      // Core never finishes: abort after 32 COMPUTE cycles (1 LOAD + 32 edges)
      core_stall = 1'b1;
      send_job(1'b1, IDENT, B_SEQ);
      wait_resp(cyc);
      check_val("to_cycles", 128'(cyc), 128'(33));
      check_val("to_err", 128'(bus_if.resp_error), 128'(1));
      check_val("to_data", bus_if.resp_data, 128'(0));
      check_val("to_id", 128'(bus_if.resp_id), 128'(1));
      take_resp();
      core_stall = 1'b0;
      send_job(1'b0, IDENT, B_SEQ);
      wait_resp(cyc);
      check_val("to_recover_err", 128'(bus_if.resp_error), 128'(0));
      check_val("to_recover_data", bus_if.resp_data, B_SEQ);
      take_resp();
`endif

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule
